// File: rtl/i2s_rx.sv
// i2s_rx -- I2S serial audio receiver, single clk domain.
//
// The bit clock, word select and serial data pins are oversampled by clk. Each pin
// passes through a SYNC_STAGES-deep synchronizer. A rising edge of the synchronized
// sck produces a one-clk strobe, and every sample is taken on that strobe. The
// receiver waits for a WS transition before it starts capturing. It captures
// DATA_BITS bits MSB-first per slot and honours the I2S one-bit WS lead, so the
// strobe that sees the new WS still carries the previous slot's LSB.
//
// Ports:
//   clk, rst_n    system clock (>= 4x sck) / async active-low reset
//   i2s_sck       I2S bit clock (async)
//   i2s_ws        I2S word select, 0 = left, 1 = right (async)
//   i2s_sd        I2S serial data, MSB first (async)
//   audio_out     last completed word (two's complement), held between pulses
//   audio_valid   one-clk pulse per new audio_out
//   audio_chan    channel of audio_out
//   frame_err     one-clk pulse when a slot ends before DATA_BITS bits arrived
//
// Build option: define I2S_RX_LEFT_ONLY_EN to suppress right-channel words.
// Right-channel words are still shifted in but are never emitted, and audio_chan
// reads constant 0.
module i2s_rx #(
    parameter int DATA_BITS   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i2s_sck,
    input  logic                 i2s_ws,
    input  logic                 i2s_sd,
    output logic [DATA_BITS-1:0] audio_out,
    output logic                 audio_valid,
    output logic                 audio_chan,
    output logic                 frame_err
);
    localparam int              CW   = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]   FULL = CW'(DATA_BITS);

    typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;

    // ---------------- synchronizers + sck edge strobe ----------------
    logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
    logic                   sck_prev;
    logic                   sck_s, ws_s, sd_s, strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i2s_sd};
            sck_prev <= sck_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ws_s   = ws_sync[SYNC_STAGES-1];
    assign sd_s   = sd_sync[SYNC_STAGES-1];
    assign strobe = sck_s & ~sck_prev;

    // ---------------- control FSM ----------------
    state_t                 state_q, state_d;
    logic                   ws_last;
    logic                   slot_chan;     // channel of the slot being shifted
    logic [CW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   done_pend;     // word completed on the previous clk
    logic                   done_chan;     // channel of that completed word

    logic                   ws_edge, capture, restart, arm_load;
    logic [CW-1:0]          cnt_after;
    logic                   word_done, err_d;

    always_comb begin
        state_d  = state_q;
        ws_edge  = (ws_s != ws_last);
        capture  = 1'b0;
        restart  = 1'b0;
        arm_load = 1'b0;
        case (state_q)
            IDLE: if (strobe) begin
                arm_load = 1'b1;
                state_d  = ARM;
            end
            ARM: if (strobe && ws_edge) begin
                restart = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: if (strobe) begin
                capture = (bit_cnt < FULL);
                restart = ws_edge;
            end
            default: state_d = IDLE;
        endcase
    end

    // Count after this strobe's capture; the WS-change decision looks at this
    // count because the edge bit still belongs to the old slot.
    assign cnt_after = bit_cnt + CW'(capture);
    assign word_done = capture && (cnt_after == FULL);
    assign err_d     = (state_q == SHIFT) && strobe && ws_edge && (cnt_after < FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_last   <= 1'b0;
            slot_chan <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            done_pend <= 1'b0;
            done_chan <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            done_pend <= word_done;
            frame_err <= err_d;
            if (word_done)
                done_chan <= slot_chan;    // old channel, before any restart below
            if (capture)
                shreg <= {shreg[DATA_BITS-2:0], sd_s};
            if (arm_load)
                ws_last <= ws_s;
            if (restart) begin
                ws_last   <= ws_s;
                slot_chan <= ws_s;
                bit_cnt   <= '0;
            end else if (capture) begin
                bit_cnt   <= cnt_after;    // stops at FULL: capture is off there
            end
        end
    end

    // ---------------- output stage ----------------
    logic emit;

`ifdef I2S_RX_LEFT_ONLY_EN
    assign emit       = done_pend & ~done_chan;
    assign audio_chan = 1'b0;
`else
    assign emit = done_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    audio_chan <= 1'b0;
        else if (emit) audio_chan <= done_chan;
    end
`endif

    // shreg is stable here: the next strobe is at least 4 clks away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_out   <= '0;
            audio_valid <= 1'b0;
        end else begin
            audio_valid <= emit;
            if (emit) audio_out <= shreg;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;
    localparam int DB = 24;
    localparam int HS = 80;   // sck half period, sck = clk/8
    localparam int HF = 40;   // fast stream, sck = clk/4

    logic          clk = 1'b0;
    logic          rst_n, i2s_sck, i2s_ws, i2s_sd;
    logic [DB-1:0] audio_out;
    logic          audio_valid, audio_chan, frame_err;

    int n_cmp = 0, n_err = 0;
    int vcnt = 0, ecnt = 0;
    logic prev_v = 1'b0, prev_e = 1'b0;
    logic [DB:0] exp_q[$];   // {chan, data}

    i2s_rx #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
        .audio_out(audio_out), .audio_valid(audio_valid), .audio_chan(audio_chan),
        .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard side: every audio_valid pops one expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (audio_valid) begin
                vcnt++;
                chk("valid_dbl", {31'b0, prev_v}, 32'd0);
                chk("sb_has_entry", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    logic [DB:0] e;
                    e = exp_q.pop_front();
                    chk("audio_out", {8'b0, audio_out}, {8'b0, e[DB-1:0]});
                    chk("audio_chan", {31'b0, audio_chan}, {31'b0, e[DB]});
                end
            end
            if (frame_err) begin
                ecnt++;
                chk("err_dbl", {31'b0, prev_e}, 32'd0);
            end
        end
        prev_v <= audio_valid;
        prev_e <= frame_err;
    end

    task automatic send_bit(input logic ws, input logic sd, input int half);
        i2s_ws  = ws;
        i2s_sd  = sd;
        i2s_sck = 1'b0;
        #(half);
        i2s_sck = 1'b1;
        #(half);
    endtask

    // One slot, MSB first; the last bit already carries the next slot's WS.
    task automatic send_slot(input logic chan, input logic [31:0] w, input int len,
                             input logic nxt, input int half);
        for (int i = 0; i < len; i++)
            send_bit((i == len - 1) ? nxt : chan, w[len-1-i], half);
    endtask

    task automatic push(input logic chan, input logic [DB-1:0] d);
`ifdef I2S_RX_LEFT_ONLY_EN
        if (!chan) exp_q.push_back({chan, d});
`else
        exp_q.push_back({chan, d});
`endif
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0;
        logic [DB-1:0] held, wd;
        rst_n = 1'b0; i2s_sck = 1'b0; i2s_ws = 1'b1; i2s_sd = 1'b0;
        #47;
        chk("rst_out",   {8'b0, audio_out}, 32'd0);
        chk("rst_valid", {31'b0, audio_valid}, 32'd0);
        chk("rst_chan",  {31'b0, audio_chan}, 32'd0);
        chk("rst_err",   {31'b0, frame_err}, 32'd0);
        rst_n = 1'b1;

        // preamble: DUT arms on the WS change to left
        send_slot(1'b1, 32'h0, 4, 1'b0, HS);

        // 24-bit slots: left A5C3F1, right 800000
        push(1'b0, 24'hA5C3F1); send_slot(1'b0, 32'hA5C3F1, 24, 1'b1, HS);
        push(1'b1, 24'h800000); send_slot(1'b1, 32'h800000, 24, 1'b0, HS);

        // 32-bit slots: 24 data bits then 8 ones, which must be discarded
        push(1'b0, 24'h123456); send_slot(1'b0, 32'h123456FF, 32, 1'b1, HS);
        push(1'b1, 24'h654321); send_slot(1'b1, 32'h654321FF, 32, 1'b0, HS);

        // short 16-bit left slot -> frame_err, no word
`ifdef I2S_RX_LEFT_ONLY_EN
        held = 24'h123456;
`else
        held = 24'h654321;
`endif
        #200;
        v0 = vcnt; e0 = ecnt;
        send_slot(1'b0, 32'h0000BEEF, 16, 1'b1, HS);
        #200;
        chk("short_err",   ecnt - e0, 32'd1);
        chk("short_valid", vcnt - v0, 32'd0);
        chk("short_hold",  {8'b0, audio_out}, {8'b0, held});
        push(1'b1, 24'h2468AC); send_slot(1'b1, 32'h2468AC, 24, 1'b0, HS);

        // reset after 10 bits of a left word
        #200;
        wd = 24'hC0FFEE;
        for (int i = 0; i < 10; i++) send_bit(1'b0, wd[DB-1-i], HS);
        rst_n = 1'b0;
        #30;
        chk("mid_rst_out",   {8'b0, audio_out}, 32'd0);
        chk("mid_rst_valid", {31'b0, audio_valid}, 32'd0);
        chk("mid_rst_chan",  {31'b0, audio_chan}, 32'd0);
        chk("mid_rst_err",   {31'b0, frame_err}, 32'd0);
        #50;
        rst_n = 1'b1;
        v0 = vcnt; e0 = ecnt;
        for (int i = 10; i < DB; i++) send_bit((i == DB - 1), wd[DB-1-i], HS);
        #200;
        chk("post_rst_valid", vcnt - v0, 32'd0);
        chk("post_rst_out",   {8'b0, audio_out}, 32'd0);
        push(1'b1, 24'h13579B); send_slot(1'b1, 32'h13579B, 24, 1'b0, HS);
        #200;
        chk("post_rst_err", ecnt - e0, 32'd0);

        // continuous stream at sck = clk/4
        e0 = ecnt;
        for (int p = 0; p < 3; p++) begin
            push(1'b0, 24'h000001); send_slot(1'b0, 32'h000001, 24, 1'b1, HF);
            push(1'b1, 24'h7FFFFF); send_slot(1'b1, 32'h7FFFFF, 24, (p != 2) ? 1'b0 : 1'b1, HF);
        end
        #400;
        chk("stream_err", ecnt - e0, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 24: audio word width captured per slot.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per serial input, minimum 2.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); single clock domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i2s_sck  input  1  I2S bit clock, asynchronous to clk.
REQ-006 SHALL have port i2s_ws  input  1  I2S word select (0 = left, 1 = right), asynchronous.
REQ-007 SHALL have port i2s_sd  input  1  I2S serial data, MSB first, asynchronous.
REQ-008 SHALL have port audio_out  output  DATA_BITS  last captured two's-complement word, feeds the equalizer's audio_in.
REQ-009 SHALL have port audio_valid  output  1  one-clk pulse marking a new audio_out, feeds the equalizer's audio_valid.
REQ-010 SHALL have port audio_chan  output  1  channel of the current audio_out (0 = left, 1 = right).
REQ-011 SHALL have port frame_err  output  1  one-clk pulse on a short slot.

Function
REQ-012 SHALL pass i2s_sck, i2s_ws and i2s_sd each through SYNC_STAGES flops clocked by clk before any use.
REQ-013 SHALL generate a one-clk strobe when synchronized sck is 1 and its previous value was 0; all sampling SHALL occur only on this strobe.
REQ-014 SHALL operate correctly for clk frequency >= 4x sck frequency; behaviour below that is undefined.
REQ-015 SHALL implement states IDLE, ARM and SHIFT; reset enters IDLE.
REQ-016 In IDLE, the first strobe SHALL load ws_last with sampled ws and move to ARM; no capture.
REQ-017 In ARM, a strobe with sampled ws != ws_last SHALL clear bit_cnt, latch the channel, update ws_last and enter SHIFT; other strobes SHALL be ignored.
REQ-018 In SHIFT, each strobe with bit_cnt < DATA_BITS SHALL shift sampled sd into the LSB of the shift register and increment bit_cnt.
REQ-019 When bit_cnt reaches DATA_BITS, the next clk edge SHALL load audio_out with the shift register, audio_chan with the latched channel, and pulse audio_valid for exactly one clk.
REQ-020 Bits after DATA_BITS within a slot (for example, 32-bit slots) SHALL be discarded; bit_cnt SHALL saturate at DATA_BITS.
REQ-021 A strobe with sampled ws != ws_last in SHIFT SHALL apply REQ-018/019 first, so that edge's bit is the previous slot's last bit (I2S one-bit delay). It SHALL then clear bit_cnt, latch the new channel and update ws_last.
REQ-022 If such a WS change finds bit_cnt < DATA_BITS after the REQ-018 capture, that word SHALL be dropped (no audio_valid), and frame_err SHALL pulse for one clk.
REQ-023 audio_valid SHALL rise at the (SYNC_STAGES+2)th clk rising edge after the pin sck rising edge carrying the LSB, within +1 clk for sampling uncertainty.
REQ-024 audio_out and audio_chan SHALL hold their values between pulses; audio_valid and frame_err SHALL never be high in two consecutive clks.

Reset
REQ-025 rst_n low SHALL asynchronously clear audio_out, audio_valid, audio_chan, frame_err, the shift register, bit_cnt, ws_last and all synchronizer flops to 0, and force IDLE.
REQ-026 Reset asserted mid-word SHALL discard the partial word; after release, no word SHALL be emitted before a complete ARM-to-SHIFT sequence.

Configuration
REQ-027 When macro I2S_RX_LEFT_ONLY_EN is defined, right-channel words SHALL be captured but not emitted: audio_valid stays low and audio_out is unchanged; audio_chan SHALL be tied to 0.
REQ-028 When I2S_RX_LEFT_ONLY_EN is undefined, both channels SHALL be emitted with audio_chan per REQ-019.

Verification
REQ-029 Bench SHALL drive 24-bit slots, left word 0xA5C3F1 -> single audio_valid, audio_out=0xA5C3F1, audio_chan=0.
REQ-030 Bench SHALL drive 32-bit slots, left 0x123456 then 8 bits of 1 -> audio_out=0x123456, exactly one valid pulse per slot.
REQ-031 Bench SHALL drive a 16-bit left slot followed by a WS change -> frame_err one pulse, no audio_valid, audio_out unchanged.
REQ-032 Bench SHALL pull rst_n low after 10 bits of a word, then release -> all outputs 0; no valid until after the next WS change plus 24 bits.
REQ-033 Bench SHALL drive right word 0x800000 -> without the macro, valid with audio_out=0x800000 and audio_chan=1; with I2S_RX_LEFT_ONLY_EN defined, no valid.
REQ-034 Bench SHALL drive continuous L/R stream 0x000001/0x7FFFFF at sck = clk/4 -> alternating bit-exact outputs, no frame_err.
